axi_st_patgen_seq_ctrl: RTL

AXI_ST_PATGEN_SEQ_CTRL -- requirements
Module: axi_st_patgen_seq_ctrl

---
 rtl/axist_pkg.sv | 59 +++++
 rtl/axist_tmo_cntr.sv | 51 +++++
 rtl/axi_st_patgen_seq_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axist_pkg
//  Description : Shared definitions for the AXI-stream pattern-generator test
//                sequencer: sequencer state encoding, pattern-select codes,
//                pattern-mask bit positions and mask helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package axist_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_LAUNCH   = 3'd2,
        ST_RUN      = 3'd3,
        ST_WAIT_CHK = 3'd4,
        ST_NEXT     = 3'd5,
        ST_FINISH   = 3'd6
    } state_e;

    // Pattern-select codes driven to the generator
    localparam logic [1:0] SEL_FIXED = 2'b00;
    localparam logic [1:0] SEL_RAND  = 2'b01;
    localparam logic [1:0] SEL_INCR  = 2'b10;

    // Bit positions inside pat_mask
    localparam int MASK_BIT_FIXED = 0;
    localparam int MASK_BIT_RAND  = 1;
    localparam int MASK_BIT_INCR  = 2;

    // Select code for the lowest set bit of the still-available mask.
    function automatic logic [1:0] pick_sel(input logic [2:0] avail);
        logic [1:0] sel;
        sel = SEL_INCR;
        if (avail[MASK_BIT_FIXED]) begin
            sel = SEL_FIXED;
        end else if (avail[MASK_BIT_RAND]) begin
            sel = SEL_RAND;
        end
        return sel;
    endfunction

    // One-hot of the lowest set bit of the still-available mask.
    function automatic logic [2:0] pick_bit(input logic [2:0] avail);
        logic [2:0] one_hot;
        one_hot = 3'b000;
        if (avail[MASK_BIT_FIXED]) begin
            one_hot[MASK_BIT_FIXED] = 1'b1;
        end else if (avail[MASK_BIT_RAND]) begin
            one_hot[MASK_BIT_RAND] = 1'b1;
        end else if (avail[MASK_BIT_INCR]) begin
            one_hot[MASK_BIT_INCR] = 1'b1;
        end
        return one_hot;
    endfunction

endpackage : axist_pkg
`default_nettype wire

// File: rtl/axist_tmo_cntr.sv
`default_nettype none
// ============================================================================
//  Module      : axist_tmo_cntr
//  Description : Per-burst idle-cycle timeout counter. Counts enabled cycles
//                without a clear; flags expiry on the cycle in which the count
//                reaches the limit. A zero limit never expires.
//  Ports       : clk    - clock (rising edge)
//                rst    - asynchronous active-high reset
//                en     - count this cycle
//                clr    - restart the count (wins over en)
//                limit  - idle-cycle limit, 0 disables
//                expire - limit reached this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module axist_tmo_cntr #(
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [TMO_W-1:0] limit,
    output logic             expire
);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the idle cycle that brings the count up to the limit, so the
    // sequencer leaves on the same edge at which the counter hits the limit.
    assign expire = en && !clr && (limit != '0) && (cnt_q == (limit - 1'b1));

endmodule : axist_tmo_cntr
`default_nettype wire

// File: rtl/axi_st_patgen_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : axi_st_patgen_seq_ctrl
//  Description : Test sequencer for an AXI-stream pattern generator/checker
//                pair. Walks the enabled patterns (fixed, random, increment)
//                for a number of loops, launching one burst per pattern,
//                tallying checker verdicts and guarding each burst with an
//                idle-cycle timeout. Abort or timeout ends the run early.
//  Ports       : wr_clk, rst           - clock, async active-high reset
//                start, abort          - run control
//                pat_mask, burst_len,
//                num_loops, tmo_limit  - run configuration (captured at start)
//                patgen_data_wr        - beat strobe from the generator
//                chkr_done, chkr_pass  - checker verdict
//                patgen_en/sel/cnt     - generator launch interface
//                busy, done            - run status
//                pass_cnt, fail_cnt,
//                tmo_err               - run results
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_st_patgen_seq_ctrl #(
    parameter int TMO_W  = 16,
    parameter int LOOP_W = 8
) (
    input  logic              wr_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        pat_mask,
    input  logic [8:0]        burst_len,
    input  logic [LOOP_W-1:0] num_loops,
    input  logic [TMO_W-1:0]  tmo_limit,
    input  logic              patgen_data_wr,
    input  logic              chkr_done,
    input  logic              chkr_pass,
    output logic              patgen_en,
    output logic [1:0]        patgen_sel,
    output logic [8:0]        patgen_cnt,
    output logic              busy,
    output logic              done,
    output logic [LOOP_W-1:0] pass_cnt,
    output logic [LOOP_W-1:0] fail_cnt,
    output logic              tmo_err
);

    import axist_pkg::*;

    localparam logic [LOOP_W-1:0] LOOP_ONE = {{(LOOP_W-1){1'b0}}, 1'b1};

    // FSM state
    state_e state_q, state_d;

    // Captured configuration
    logic [2:0]        mask_q, mask_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [LOOP_W-1:0] loops_q, loops_d;
    logic [TMO_W-1:0]  limit_q, limit_d;

    // Run bookkeeping
    logic [2:0]        ran_q, ran_d;
    logic [LOOP_W-1:0] loop_idx_q, loop_idx_d;
    logic [8:0]        beat_q, beat_d;
    logic              pend_q, pend_d;
    logic              pend_pass_q, pend_pass_d;

    // Registered outputs
    logic              patgen_en_q, patgen_en_d;
    logic [1:0]        sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [LOOP_W-1:0] pass_q, pass_d;
    logic [LOOP_W-1:0] fail_q, fail_d;
    logic              tmo_err_q, tmo_err_d;

    // Combinational helpers
    logic [2:0]        avail;
    logic              run_done;
    logic              chk_hit;
    logic              chk_ok;
    logic              abort_hit;
    logic              tmo_en;
    logic              tmo_clr;
    logic              tmo_expire;
    logic              tmo_fire;
    logic [LOOP_W:0]   loop_nxt;
    logic              more_loops;

    assign avail     = mask_q & ~ran_q;
    assign run_done  = (beat_q == cnt_q);
    // An early verdict held in the pending flag counts as soon as WAIT_CHK
    // is entered and takes precedence over a same-cycle live strobe.
    assign chk_hit   = (state_q == ST_WAIT_CHK) && (chkr_done || pend_q);
    assign chk_ok    = pend_q ? pend_pass_q : chkr_pass;
    // FINISH already heads to IDLE; redirecting it again would repeat done.
    assign abort_hit = abort && (state_q != ST_IDLE) && (state_q != ST_FINISH);

    assign loop_nxt   = {1'b0, loop_idx_q} + 1'b1;
    assign more_loops = (loop_nxt < {1'b0, loops_q});

    assign tmo_en  = (state_q == ST_RUN) || (state_q == ST_WAIT_CHK);
    assign tmo_clr = (state_q == ST_LAUNCH) || patgen_data_wr || chkr_done;

    // Burst completion wins over a coincident expiry.
    assign tmo_fire = tmo_expire &&
                      (((state_q == ST_RUN) && !run_done) ||
                       ((state_q == ST_WAIT_CHK) && !chk_hit));

    axist_tmo_cntr #(
        .TMO_W (TMO_W)
    ) u_tmo_cntr (
        .clk    (wr_clk),
        .rst    (rst),
        .en     (tmo_en),
        .clr    (tmo_clr),
        .limit  (limit_q),
        .expire (tmo_expire)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (pat_mask != 3'b000) ? ST_SELECT : ST_FINISH;
                end
            end
            ST_SELECT:   state_d = ST_LAUNCH;
            ST_LAUNCH:   state_d = ST_RUN;
            ST_RUN: begin
                if (run_done) begin
                    state_d = ST_WAIT_CHK;
                end else if (tmo_fire) begin
                    state_d = ST_FINISH;
                end
            end
            ST_WAIT_CHK: begin
                if (chk_hit) begin
                    state_d = ST_NEXT;
                end else if (tmo_fire) begin
                    state_d = ST_FINISH;
                end
            end
            ST_NEXT: begin
                if ((avail != 3'b000) || more_loops) begin
                    state_d = ST_SELECT;
                end else begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH:   state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        if (abort_hit) begin
            state_d = ST_FINISH;
        end
    end

    // ------------------------------------------------------------------
    // Output and datapath next-values
    // ------------------------------------------------------------------
    always_comb begin
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        loops_d     = loops_q;
        limit_d     = limit_q;
        ran_d       = ran_q;
        loop_idx_d  = loop_idx_q;
        beat_d      = beat_q;
        pend_d      = pend_q;
        pend_pass_d = pend_pass_q;
        sel_d       = sel_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        tmo_err_d   = tmo_err_q;

        // Status outputs are decoded from the upcoming state so that the
        // registered value lines up with the state it describes.
        patgen_en_d = (state_d == ST_LAUNCH);
        done_d      = (state_d == ST_FINISH);
        busy_d      = (state_d != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start && (pat_mask != 3'b000)) begin
                    mask_d     = pat_mask;
                    cnt_d      = burst_len;
                    loops_d    = (num_loops == '0) ? LOOP_ONE : num_loops;
                    limit_d    = tmo_limit;
                    ran_d      = 3'b000;
                    loop_idx_d = '0;
                    pass_d     = '0;
                    fail_d     = '0;
                    tmo_err_d  = 1'b0;
                end
            end
            ST_SELECT: begin
                sel_d = pick_sel(avail);
                ran_d = ran_q | pick_bit(avail);
            end
            ST_LAUNCH: begin
                beat_d      = '0;
                pend_d      = 1'b0;
                pend_pass_d = 1'b0;
            end
            ST_RUN: begin
                if (patgen_data_wr && !run_done) begin
                    beat_d = beat_q + 1'b1;
                end
                if (chkr_done && !pend_q) begin
                    pend_d      = 1'b1;
                    pend_pass_d = chkr_pass;
                end
            end
            ST_WAIT_CHK: begin
                if (chk_hit && !abort_hit) begin
                    pend_d = 1'b0;
                    if (chk_ok) begin
                        if (pass_q != '1) begin
                            pass_d = pass_q + 1'b1;
                        end
                    end else begin
                        if (fail_q != '1) begin
                            fail_d = fail_q + 1'b1;
                        end
                    end
                end
            end
            ST_NEXT: begin
                if (avail == 3'b000) begin
                    loop_idx_d = loop_nxt[LOOP_W-1:0];
                    if (more_loops) begin
                        ran_d = 3'b000;
                    end
                end
            end
            default: begin
            end
        endcase

        if (abort_hit || tmo_fire) begin
            tmo_err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            mask_q      <= 3'b000;
            cnt_q       <= '0;
            loops_q     <= '0;
            limit_q     <= '0;
            ran_q       <= 3'b000;
            loop_idx_q  <= '0;
            beat_q      <= '0;
            pend_q      <= 1'b0;
            pend_pass_q <= 1'b0;
            patgen_en_q <= 1'b0;
            sel_q       <= SEL_FIXED;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= '0;
            fail_q      <= '0;
            tmo_err_q   <= 1'b0;
        end else begin
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            loops_q     <= loops_d;
            limit_q     <= limit_d;
            ran_q       <= ran_d;
            loop_idx_q  <= loop_idx_d;
            beat_q      <= beat_d;
            pend_q      <= pend_d;
            pend_pass_q <= pend_pass_d;
            patgen_en_q <= patgen_en_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    assign patgen_en  = patgen_en_q;
    assign patgen_sel = sel_q;
    assign patgen_cnt = cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass_cnt   = pass_q;
    assign fail_cnt   = fail_q;
    assign tmo_err    = tmo_err_q;

endmodule : axi_st_patgen_seq_ctrl
`default_nettype wire
